// File: rtl/standoff_referee_pkg.sv
// Shared action codes, winner codes, referee state encoding and capture record
// for the two-player standoff referee.
package standoff_referee_pkg;

  localparam logic [2:0] ACT_BLOCK  = 3'b001;
  localparam logic [2:0] ACT_RELOAD = 3'b010;
  localparam logic [2:0] ACT_SHOOT  = 3'b100;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_OVER    = 2'd3
  } ref_state_e;

  typedef struct packed {
    logic [2:0] action;
    logic [1:0] bullets;
  } player_cap_t;

  // Exact compare against the one-hot code makes every non-one-hot action inert.
  function automatic logic eff_shot(input player_cap_t p);
    return (p.action == ACT_SHOOT) && (p.bullets != 2'd0);
  endfunction

endpackage

// File: rtl/standoff_referee_if.sv
// Game-side bus of the referee: round inputs from the players and the
// registered score/result outputs for the display stage.
interface standoff_referee_if #(
  parameter int LIFE_W  = 2,
  parameter int ROUND_W = 5
);
  logic               start;
  logic               round_tick;
  logic [2:0]         p1_action;
  logic [2:0]         p2_action;
  logic [1:0]         p1_bullets;
  logic [1:0]         p2_bullets;
  logic [LIFE_W-1:0]  p1_lives;
  logic [LIFE_W-1:0]  p2_lives;
  logic [ROUND_W-1:0] round_num;
  logic               p1_hit;
  logic               p2_hit;
  logic               in_play;
  logic               game_over;
  logic [1:0]         winner;

  modport master (
    output start, round_tick, p1_action, p2_action, p1_bullets, p2_bullets,
    input  p1_lives, p2_lives, round_num, p1_hit, p2_hit, in_play, game_over, winner
  );

  modport slave (
    input  start, round_tick, p1_action, p2_action, p1_bullets, p2_bullets,
    output p1_lives, p2_lives, round_num, p1_hit, p2_hit, in_play, game_over, winner
  );
endinterface

// File: rtl/standoff_round_judge.sv
// Combinational round outcome: who gets hit, given both captured actions and
// the bullet counts held before the round.
module standoff_round_judge
  import standoff_referee_pkg::*;
(
  input  player_cap_t p1_cap,
  input  player_cap_t p2_cap,
  output logic        p1_hit_n,
  output logic        p2_hit_n
);

  // A NONE action is not a block, so it leaves the player exposed.
  assign p2_hit_n = eff_shot(p1_cap) && (p2_cap.action != ACT_BLOCK);
  assign p1_hit_n = eff_shot(p2_cap) && (p1_cap.action != ACT_BLOCK);

endmodule

// File: rtl/standoff_referee.sv
// Referee FSM: captures a round on round_tick, resolves it one cycle later,
// keeps lives/round counters and latches the winner when the game ends.
module standoff_referee
  import standoff_referee_pkg::*;
#(
  parameter int START_LIVES = 3,
  parameter int LIFE_W      = 2,
  parameter int MAX_ROUNDS  = 20,
  parameter int ROUND_W     = 5
) (
  input logic               clk,
  input logic               reset,
  standoff_referee_if.slave bus
);

  localparam logic [LIFE_W-1:0]  LIVES_INIT  = LIFE_W'(START_LIVES);
  localparam logic [ROUND_W-1:0] ROUND_LIMIT = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] ROUND_SAT   = '1;

  ref_state_e         state_q, state_d;
  player_cap_t        p1_cap_q, p1_cap_d, p2_cap_q, p2_cap_d;
  logic [LIFE_W-1:0]  p1_lives_q, p1_lives_d, p2_lives_q, p2_lives_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
  logic               in_play_q, in_play_d, game_over_q, game_over_d;
  winner_e            winner_q, winner_d;
  logic               p1_hit_n, p2_hit_n;

  standoff_round_judge u_judge (
    .p1_cap   (p1_cap_q),
    .p2_cap   (p2_cap_q),
    .p1_hit_n (p1_hit_n),
    .p2_hit_n (p2_hit_n)
  );

  always_comb begin
    state_d    = state_q;
    p1_cap_d   = p1_cap_q;
    p2_cap_d   = p2_cap_q;
    p1_lives_d = p1_lives_q;
    p2_lives_d = p2_lives_q;
    round_d    = round_q;
    winner_d   = winner_q;
    p1_hit_d   = 1'b0;
    p2_hit_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d    = ST_PLAY;
          p1_lives_d = LIVES_INIT;
          p2_lives_d = LIVES_INIT;
          round_d    = '0;
          winner_d   = WIN_NONE;
        end
      end
      ST_PLAY: begin
        if (bus.round_tick) begin
          p1_cap_d = '{action: bus.p1_action, bullets: bus.p1_bullets};
          p2_cap_d = '{action: bus.p2_action, bullets: bus.p2_bullets};
          state_d  = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        p1_hit_d = p1_hit_n;
        p2_hit_d = p2_hit_n;
        if (p1_hit_n && (p1_lives_q != '0)) p1_lives_d = p1_lives_q - LIFE_W'(1);
        if (p2_hit_n && (p2_lives_q != '0)) p2_lives_d = p2_lives_q - LIFE_W'(1);
        if (round_q != ROUND_SAT) round_d = round_q + ROUND_W'(1);

        if ((p1_lives_d == '0) || (p2_lives_d == '0)) begin
          state_d = ST_OVER;
          if ((p1_lives_d == '0) && (p2_lives_d == '0)) winner_d = WIN_DRAW;
          else if (p1_lives_d == '0)                    winner_d = WIN_P2;
          else                                          winner_d = WIN_P1;
        end else if ((MAX_ROUNDS != 0) && (round_d == ROUND_LIMIT)) begin
          state_d = ST_OVER;
          if (p1_lives_d > p2_lives_d)      winner_d = WIN_P1;
          else if (p2_lives_d > p1_lives_d) winner_d = WIN_P2;
          else                              winner_d = WIN_DRAW;
        end else begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_play_d   = (state_d == ST_PLAY) || (state_d == ST_RESOLVE);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      p1_cap_q    <= '0;
      p2_cap_q    <= '0;
      p1_lives_q  <= LIVES_INIT;
      p2_lives_q  <= LIVES_INIT;
      round_q     <= '0;
      p1_hit_q    <= 1'b0;
      p2_hit_q    <= 1'b0;
      in_play_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      p1_cap_q    <= p1_cap_d;
      p2_cap_q    <= p2_cap_d;
      p1_lives_q  <= p1_lives_d;
      p2_lives_q  <= p2_lives_d;
      round_q     <= round_d;
      p1_hit_q    <= p1_hit_d;
      p2_hit_q    <= p2_hit_d;
      in_play_q   <= in_play_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.p1_lives  = p1_lives_q;
  assign bus.p2_lives  = p2_lives_q;
  assign bus.round_num = round_q;
  assign bus.p1_hit    = p1_hit_q;
  assign bus.p2_hit    = p2_hit_q;
  assign bus.in_play   = in_play_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_standoff_referee.sv
// Bench for standoff_referee: single-round vector table, hand sequences for
// game end / reset / ignored ticks, and random games against a round-level model.
module tb_standoff_referee;

  logic       clk = 1'b0;
  logic       reset, start, tick;
  logic [2:0] a1, a2;
  logic [1:0] b1, b2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  standoff_referee_if ifa ();
  standoff_referee_if ifb ();

  assign ifa.start = start;  assign ifa.round_tick = tick;
  assign ifa.p1_action = a1; assign ifa.p2_action = a2;
  assign ifa.p1_bullets = b1; assign ifa.p2_bullets = b2;
  assign ifb.start = start;  assign ifb.round_tick = tick;
  assign ifb.p1_action = a1; assign ifb.p2_action = a2;
  assign ifb.p1_bullets = b1; assign ifb.p2_bullets = b2;

  standoff_referee #(.START_LIVES(3), .LIFE_W(2), .MAX_ROUNDS(20), .ROUND_W(5))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  standoff_referee #(.START_LIVES(3), .LIFE_W(2), .MAX_ROUNDS(2), .ROUND_W(5))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    a1 = 3'b010; a2 = 3'b010; b1 = 2'd0; b2 = 2'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  // Ends one negedge after the resolve edge, where hits/lives are visible.
  task automatic play_round(input logic [2:0] x1, input logic [1:0] y1,
                            input logic [2:0] x2, input logic [1:0] y2);
    a1 = x1; b1 = y1; a2 = x2; b2 = y2; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  // Round-level model: a shot lands if it is a real one-hot shoot with ammo
  // and the target is not holding a real one-hot block.
  function automatic bit lands(input logic [2:0] sa, input logic [1:0] sb, input logic [2:0] ta);
    bit shoots, blocks;
    shoots = ($countones(sa) == 1) && sa[2] && (sb > 0);
    blocks = ($countones(ta) == 1) && ta[0];
    return shoots && !blocks;
  endfunction

  function automatic int winner_of(input int l1, input int l2);
    if (l1 == 0 && l2 == 0) return 3;
    if (l1 == 0) return 2;
    if (l2 == 0) return 1;
    if (l1 > l2) return 1;
    if (l2 > l1) return 2;
    return 3;
  endfunction

  typedef struct {
    logic [2:0] a1; logic [1:0] b1; logic [2:0] a2; logic [1:0] b2;
    int h1; int h2; int l1; int l2;
  } vec_t;

  vec_t vecs[10];
  logic [2:0] act_pool[10];

  initial begin
    vecs[0] = '{3'b100, 2'd1, 3'b010, 2'd0, 0, 1, 3, 2};
    vecs[1] = '{3'b100, 2'd2, 3'b001, 2'd0, 0, 0, 3, 3};
    vecs[2] = '{3'b100, 2'd0, 3'b010, 2'd0, 0, 0, 3, 3};
    vecs[3] = '{3'b100, 2'd3, 3'b000, 2'd0, 0, 1, 3, 2};
    vecs[4] = '{3'b100, 2'd1, 3'b110, 2'd2, 0, 1, 3, 2};
    vecs[5] = '{3'b100, 2'd2, 3'b100, 2'd1, 1, 1, 2, 2};
    vecs[6] = '{3'b010, 2'd0, 3'b100, 2'd3, 1, 0, 2, 3};
    vecs[7] = '{3'b001, 2'd0, 3'b100, 2'd1, 0, 0, 3, 3};
    vecs[8] = '{3'b111, 2'd3, 3'b100, 2'd2, 1, 0, 2, 3};
    vecs[9] = '{3'b100, 2'd1, 3'b101, 2'd0, 0, 1, 3, 2};
    act_pool = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b000, 3'b011, 3'b110, 3'b111};

    do_reset();
    chk("reset_in_play", ifa.in_play, 0);
    chk("reset_game_over", ifa.game_over, 0);
    chk("reset_p1_lives", ifa.p1_lives, 3);
    chk("reset_p2_lives", ifa.p2_lives, 3);
    chk("reset_round", ifa.round_num, 0);
    chk("reset_winner", ifa.winner, 0);

    // Single rounds from a fresh game.
    foreach (vecs[i]) begin
      do_reset();
      start_game();
      chk($sformatf("v%0d_in_play", i), ifa.in_play, 1);
      a1 = vecs[i].a1; b1 = vecs[i].b1; a2 = vecs[i].a2; b2 = vecs[i].b2; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk($sformatf("v%0d_early_hit", i), {ifa.p1_hit, ifa.p2_hit}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_p1_hit", i), ifa.p1_hit, vecs[i].h1);
      chk($sformatf("v%0d_p2_hit", i), ifa.p2_hit, vecs[i].h2);
      chk($sformatf("v%0d_p1_lives", i), ifa.p1_lives, vecs[i].l1);
      chk($sformatf("v%0d_p2_lives", i), ifa.p2_lives, vecs[i].l2);
      chk($sformatf("v%0d_round", i), ifa.round_num, 1);
      @(negedge clk);
      chk($sformatf("v%0d_hit_pulse", i), {ifa.p1_hit, ifa.p2_hit}, 0);
    end

    // Mutual destruction over three rounds.
    do_reset();
    start_game();
    for (int r = 1; r <= 3; r++) begin
      play_round(3'b100, 2'd1, 3'b100, 2'd1);
      chk("draw_p1_lives", ifa.p1_lives, 3 - r);
      chk("draw_p2_lives", ifa.p2_lives, 3 - r);
      chk("draw_game_over", ifa.game_over, (r == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("draw_winner", ifa.winner, 3);
    chk("draw_in_play", ifa.in_play, 0);
    play_round(3'b100, 2'd3, 3'b100, 2'd3);
    @(negedge clk);
    chk("over_tick_round", ifa.round_num, 3);
    chk("over_tick_lives", ifa.p1_lives, 0);
    chk("over_tick_winner", ifa.winner, 3);
    start_game();
    chk("restart_game_over", ifa.game_over, 0);
    chk("restart_lives", ifa.p2_lives, 3);
    chk("restart_round", ifa.round_num, 0);
    chk("restart_winner", ifa.winner, 0);
    chk("restart_in_play", ifa.in_play, 1);

    // Tick held through RESOLVE counts only once.
    a1 = 3'b100; b1 = 2'd1; a2 = 3'b010; b2 = 2'd0; tick = 1'b1;
    @(negedge clk); @(negedge clk);
    tick = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("lost_tick_round", ifa.round_num, 1);
    chk("lost_tick_p2_lives", ifa.p2_lives, 2);

    // Reset in RESOLVE wins over the pending outcome.
    a1 = 3'b100; b1 = 2'd1; a2 = 3'b010; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_resolve_hit", ifa.p2_hit, 0);
    chk("rst_resolve_lives", ifa.p2_lives, 3);
    chk("rst_resolve_round", ifa.round_num, 0);
    chk("rst_resolve_in_play", ifa.in_play, 0);
    play_round(3'b100, 2'd1, 3'b010, 2'd0);
    @(negedge clk);
    chk("idle_tick_round", ifa.round_num, 0);
    chk("idle_tick_lives", ifa.p2_lives, 3);
    chk("idle_tick_in_play", ifa.in_play, 0);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_over_start", ifa.in_play, 0);

    // Round limit of 2 on the second instance.
    do_reset();
    start_game();
    play_round(3'b100, 2'd1, 3'b010, 2'd0);
    chk("lim_r1_p2_lives", ifb.p2_lives, 2);
    chk("lim_r1_game_over", ifb.game_over, 0);
    @(negedge clk);
    play_round(3'b010, 2'd0, 3'b010, 2'd1);
    chk("lim_game_over", ifb.game_over, 1);
    chk("lim_round", ifb.round_num, 2);
    chk("lim_winner", ifb.winner, 1);
    chk("lim_other_dut_play", ifa.game_over, 0);

    // Random games on the 20-round instance.
    do_reset();
    for (int g = 0; g < 30; g++) begin
      int l1, l2, rn;
      bit over;
      start_game();
      l1 = 3; l2 = 3; rn = 0; over = 0;
      while (!over) begin
        logic [2:0] x1, x2;
        logic [1:0] y1, y2;
        bit h1, h2;
        x1 = act_pool[$urandom_range(0, 9)];
        x2 = act_pool[$urandom_range(0, 9)];
        y1 = 2'($urandom_range(0, 3));
        y2 = 2'($urandom_range(0, 3));
        h2 = lands(x1, y1, x2);
        h1 = lands(x2, y2, x1);
        play_round(x1, y1, x2, y2);
        l1 = (l1 - h1 < 0) ? 0 : l1 - h1;
        l2 = (l2 - h2 < 0) ? 0 : l2 - h2;
        rn++;
        over = (l1 == 0) || (l2 == 0) || (rn == 20);
        chk("rnd_p1_hit", ifa.p1_hit, h1);
        chk("rnd_p2_hit", ifa.p2_hit, h2);
        chk("rnd_p1_lives", ifa.p1_lives, l1);
        chk("rnd_p2_lives", ifa.p2_lives, l2);
        chk("rnd_round", ifa.round_num, rn);
        chk("rnd_game_over", ifa.game_over, over);
        if (over) chk("rnd_winner", ifa.winner, winner_of(l1, l2));
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
